apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Single-outstanding APB4 requester that drives the APB slave register file (16 x 32-bit registers, word addresses 0x00-0x3C).
- Accepts commands on a valid/ready request channel and runs the APB SETUP/ACCESS sequence, including wait states.
- Returns read data and error status on a valid/ready response channel.
- Used as the bus-side front end for firmware-model and integration benches.

Parameters:
- DATA_WIDTH, 32: PWDATA/PRDATA/cmd_wdata/rsp_rdata width.
- ADDR_WIDTH, 32: PADDR/cmd_addr width.
- STRB_WIDTH, DATA_WIDTH/8: byte-strobe width.
- TIMEOUT, 16: maximum consecutive ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  bus clock, all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  request accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  STRB_WIDTH  write byte strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR, timeout, or misalignment.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  ADDR_WIDTH.
- PWDATA  out  DATA_WIDTH.
- PSTRB  out  STRB_WIDTH.
- PRDATA  in  DATA_WIDTH.
- PREADY  in  1.
- PSLVERR  in  1.

Behaviour:
- Reset:
  - When PRESET is high at a PCLK edge, state becomes IDLE.
  - All registered outputs (PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err, rsp_timeout) become 0 and the wait counter clears.
  - cmd_ready is forced 0 while PRESET is high.
  - Reset mid-SETUP/ACCESS abandons the transfer with no response.
- State machine: one-hot, IDLE=3'b001, SETUP=3'b010, ACCESS=3'b100.
- cmd_ready = IDLE && (!rsp_valid || rsp_ready) && !PRESET.
- Aligned accept at edge T (cmd_addr[1:0]==0):
  - Capture the command.
  - From T+1, state is SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven.
  - PSTRB = cmd_strb for writes, 0 for reads; PWDATA = 0 for reads.
- SETUP goes unconditionally to ACCESS (PENABLE=1) at T+2.
- PADDR, PWRITE, PWDATA and PSTRB hold constant from SETUP through the end of ACCESS.
- ACCESS with PREADY=1:
  - Next edge: IDLE, PSEL=PENABLE=0, rsp_valid=1.
  - rsp_rdata = PRDATA for reads (0 for writes); rsp_err = PSLVERR; rsp_timeout = 0.
  - Zero-wait latency: accept T -> rsp_valid T+3.
- ACCESS with PREADY=0: stay in ACCESS and increment the wait counter (width $clog2(TIMEOUT+1)). The counter clears on entering SETUP.
- Timeout: if TIMEOUT>0 and the cycle is the TIMEOUT-th consecutive ACCESS cycle with PREADY=0:
  - Next edge: IDLE, PSEL=PENABLE=0.
  - rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - A PREADY arriving in that same cycle wins (normal completion).
- Misaligned accept (cmd_addr[1:0]!=0): no APB transfer (PSEL stays 0); at the next edge rsp_valid=1, rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Response channel:
  - rsp_* hold stable until rsp_valid&&rsp_ready, then rsp_valid clears the same edge.
  - If a new response is produced in that same edge, it loads and rsp_valid stays 1.
- Throughput: with rsp_ready tied high, the next accept is possible at T+3 (the cycle rsp_valid is asserted).
- PSLVERR and PRDATA are ignored outside ACCESS&&PREADY.
- The address is passed unmodified to PADDR; no address-range check (the slave reports out-of-range addresses via PSLVERR).

Test Plan:
- Reset: PRESET=1 for 2 cycles with cmd_valid=1 -> cmd_ready=0, PSEL=PENABLE=0, rsp_valid=0 throughout; after release, cmd_ready=1.
- Write then read, zero wait:
  - Write 0xDEADBEEF, strb 4'hF, to 0x1C -> PSEL at T+1, PENABLE at T+2, PSTRB=4'hF, rsp_valid T+3 with rsp_err=0, rsp_rdata=0.
  - Read 0x1C with PRDATA=0xDEADBEEF -> PSTRB=0, rsp_rdata=0xDEADBEEF.
- Wait states and error: read 0x04 with PREADY low 3 cycles then high with PSLVERR=1 -> ACCESS lasts 4 cycles with PADDR stable, rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT=16, read 0x3C with PREADY held low -> exactly 16 ACCESS cycles, PSEL drops, rsp_err=1, rsp_timeout=1, rsp_rdata=0. With PREADY=1 on the 16th cycle -> normal response, rsp_timeout=0.
- Misaligned and back-pressure:
  - Write to 0x1E -> PSEL never asserts; rsp_err=1 one cycle after accept.
  - With rsp_ready=0 for 5 cycles -> rsp held and cmd_ready=0 until the handshake.
- Reset mid-ACCESS: assert PRESET during the 2nd wait cycle -> next edge PSEL=PENABLE=0, rsp_valid=0, no response ever issued; a subsequent read of 0x08 completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB4 requester bridge: one outstanding command at a time, taken from a
// valid/ready request channel, run through SETUP/ACCESS with wait-state and
// timeout handling, and answered on a valid/ready response channel.
module apb_master_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    // request channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB requester side
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // A zero TIMEOUT still needs a legal one-bit counter.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        SETUP  = 3'b010,
        ACCESS = 3'b100
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        wait_cnt, wait_cnt_nxt;

    logic                    psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_nxt;
    logic [DATA_WIDTH-1:0]   pwdata_nxt;
    logic [STRB_WIDTH-1:0]   pstrb_nxt;
    logic                    rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
    logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;

    logic                    accept;
    logic                    misaligned;
    logic                    timeout_hit;

    assign cmd_ready   = (state == IDLE) && (!rsp_valid || rsp_ready) && !PRESET;
    assign accept      = cmd_valid && cmd_ready;
    assign misaligned  = |cmd_addr[1:0];
    // Last permitted wait cycle of this ACCESS phase with PREADY still low.
    assign timeout_hit = (TIMEOUT > 0) && !PREADY && (wait_cnt == LAST_WAIT);

    // Next-state and next-output decode; everything holds unless changed.
    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        psel_nxt        = PSEL;
        penable_nxt     = PENABLE;
        pwrite_nxt      = PWRITE;
        paddr_nxt       = PADDR;
        pwdata_nxt      = PWDATA;
        pstrb_nxt       = PSTRB;
        rsp_valid_nxt   = rsp_valid && !rsp_ready;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_err_nxt     = rsp_err;
        rsp_timeout_nxt = rsp_timeout;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        // Rejected locally; the bus is never touched.
                        rsp_valid_nxt   = 1'b1;
                        rsp_rdata_nxt   = '0;
                        rsp_err_nxt     = 1'b1;
                        rsp_timeout_nxt = 1'b0;
                    end else begin
                        state_nxt    = SETUP;
                        wait_cnt_nxt = '0;
                        psel_nxt     = 1'b1;
                        penable_nxt  = 1'b0;
                        pwrite_nxt   = cmd_write;
                        paddr_nxt    = cmd_addr;
                        pwdata_nxt   = cmd_write ? cmd_wdata : '0;
                        pstrb_nxt    = cmd_write ? cmd_strb  : '0;
                    end
                end
            end
            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_nxt       = IDLE;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = (PWRITE || PSLVERR) ? '0 : PRDATA;
                    rsp_err_nxt     = PSLVERR;
                    rsp_timeout_nxt = 1'b0;
                end else if (timeout_hit) begin
                    state_nxt       = IDLE;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = '0;
                    rsp_err_nxt     = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                end else if (TIMEOUT > 0) begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
            end
        endcase
    end

    // State, wait counter and all registered outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            PSEL        <= psel_nxt;
            PENABLE     <= penable_nxt;
            PWRITE      <= pwrite_nxt;
            PADDR       <= paddr_nxt;
            PWDATA      <= pwdata_nxt;
            PSTRB       <= pstrb_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: vector table, APB responder
// model, and a response scoreboard checked on each response handshake.
module tb_apb_master_bridge;

    logic        PCLK      = 1'b0;
    logic        PRESET    = 1'b1;
    logic        cmd_valid = 1'b1;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = 32'h1C;
    logic [31:0] cmd_wdata = 32'h0;
    logic [3:0]  cmd_strb  = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    apb_master_bridge #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .STRB_WIDTH(4),
        .TIMEOUT(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    initial forever #5 PCLK = ~PCLK;
    initial forever begin
        @(posedge PCLK);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          cyc;   // cycle rsp_valid must first show; -1 = not checked
    } exp_t;
    exp_t sb[$];

    initial forever begin
        @(negedge PCLK);
        if (!PRESET && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got response rdata=%h err=%b expected none", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                if (e.cyc >= 0) check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // ---------------- APB responder ----------------
    int          slave_waits  = 0;
    logic [31:0] slave_prdata = 32'h0;
    logic        slave_err    = 1'b0;
    int          setup_cnt    = 0;
    int          acc_cnt      = 0;
    bit          unstable     = 1'b0;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_strb;
    logic        snap_write;

    // Junk PRDATA / PSLVERR=1 whenever the bridge should be ignoring them.
    initial begin
        int wcnt;
        wcnt    = 0;
        PREADY  = 1'b0;
        PSLVERR = 1'b1;
        PRDATA  = 32'hBAD0BAD0;
        forever begin
            @(negedge PCLK);
            if (PSEL && !PENABLE) begin
                setup_cnt++;
                snap_addr  = PADDR;
                snap_wdata = PWDATA;
                snap_strb  = PSTRB;
                snap_write = PWRITE;
            end
            if (PSEL && PENABLE) begin
                acc_cnt++;
                if (PADDR !== snap_addr || PWDATA !== snap_wdata ||
                    PSTRB !== snap_strb || PWRITE !== snap_write) unstable = 1'b1;
                if (wcnt < slave_waits) begin
                    PREADY  = 1'b0;
                    PSLVERR = 1'b1;
                    PRDATA  = 32'hBAD0BAD0;
                    wcnt++;
                end else begin
                    PREADY  = 1'b1;
                    PSLVERR = slave_err;
                    PRDATA  = slave_prdata;
                end
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b1;
                PRDATA  = 32'hBAD0BAD0;
                wcnt    = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Returns the cycle in which the handshake occurred.
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int t);
        bit ok;
        ok        = 1'b0;
        t         = -100;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge PCLK);
            if (cmd_ready) begin
                t  = cyc;
                ok = 1'b1;
                @(posedge PCLK);
                #1;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge PCLK);
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge PCLK);
        #1;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] prdata;
        int          waits;
        logic        slverr;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_tmo;
        int          e_acc;
        int          e_lat;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int t;
        slave_waits  = v.waits;
        slave_prdata = v.prdata;
        slave_err    = v.slverr;
        setup_cnt    = 0;
        acc_cnt      = 0;
        unstable     = 1'b0;
        send_cmd(v.w, v.addr, v.wdata, v.strb, t);
        sb.push_back('{v.e_rdata, v.e_err, v.e_tmo, t + v.e_lat});
        wait_drain();
        check("setup_cycles", 32'(setup_cnt), (v.addr[1:0] == 2'b00) ? 32'd1 : 32'd0);
        check("access_cycles", 32'(acc_cnt), 32'(v.e_acc));
        check("apb_stable", 32'(unstable), 32'd0);
        if (v.addr[1:0] == 2'b00) begin
            check("paddr", snap_addr, v.addr);
            check("pwrite", 32'(snap_write), 32'(v.w));
            check("pstrb", 32'(snap_strb), v.w ? 32'(v.strb) : 32'd0);
            check("pwdata", snap_wdata, v.w ? v.wdata : 32'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs[9];

    initial begin
        int ta, tb;
        //            w     addr    wdata         strb  prdata        waits slverr e_rdata       err   tmo   acc lat
        vecs[0] = '{1'b1, 32'h1C, 32'hDEADBEEF, 4'hF, 32'h00000000, 0,    1'b0, 32'h00000000, 1'b0, 1'b0, 1,  3};
        vecs[1] = '{1'b0, 32'h1C, 32'h00000000, 4'hF, 32'hDEADBEEF, 0,    1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1,  3};
        vecs[2] = '{1'b0, 32'h04, 32'h00000000, 4'h0, 32'h000055AA, 3,    1'b1, 32'h00000000, 1'b1, 1'b0, 4,  6};
        vecs[3] = '{1'b1, 32'h20, 32'h0BADF00D, 4'h3, 32'hFFFFFFFF, 1,    1'b0, 32'h00000000, 1'b0, 1'b0, 2,  4};
        vecs[4] = '{1'b1, 32'h1E, 32'h11111111, 4'hF, 32'h00000000, 0,    1'b0, 32'h00000000, 1'b1, 1'b0, 0,  1};
        vecs[5] = '{1'b0, 32'h3C, 32'h00000000, 4'h0, 32'h12121212, 1000, 1'b0, 32'h00000000, 1'b1, 1'b1, 16, 18};
        vecs[6] = '{1'b0, 32'h3C, 32'h00000000, 4'h0, 32'hCAFE0001, 15,   1'b0, 32'hCAFE0001, 1'b0, 1'b0, 16, 18};
        vecs[7] = '{1'b0, 32'h3D, 32'h00000000, 4'h0, 32'h00000000, 0,    1'b0, 32'h00000000, 1'b1, 1'b0, 0,  1};
        vecs[8] = '{1'b1, 32'h100, 32'hA5A5A5A5, 4'h5, 32'h00000000, 2,   1'b1, 32'h00000000, 1'b1, 1'b0, 3,  5};

        // Reset held for two cycles with a command pending.
        for (int i = 0; i < 2; i++) begin
            @(negedge PCLK);
            check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
            check("reset_psel", 32'(PSEL), 32'd0);
            check("reset_penable", 32'(PENABLE), 32'd0);
            check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        check("reset_paddr", PADDR, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
        cmd_valid = 1'b0;
        PRESET    = 1'b0;
        @(negedge PCLK);
        check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge PCLK);
        #1;

        // Table of single transactions.
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Back-to-back throughput with rsp_ready high.
        slave_waits  = 0;
        slave_prdata = 32'h0F0F0F0F;
        slave_err    = 1'b0;
        send_cmd(1'b0, 32'h1C, 32'h0, 4'h0, ta);
        sb.push_back('{32'h0F0F0F0F, 1'b0, 1'b0, ta + 3});
        send_cmd(1'b1, 32'h24, 32'h77777777, 4'hF, tb);
        sb.push_back('{32'h00000000, 1'b0, 1'b0, tb + 3});
        check("throughput_accept", 32'(tb), 32'(ta + 3));
        wait_drain();

        // Back-pressure: response held, next command stalled, then a
        // misaligned command reloads the response in the handshake cycle.
        rsp_ready    = 1'b0;
        slave_prdata = 32'h12345678;
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0, ta);
        sb.push_back('{32'h12345678, 1'b0, 1'b0, -1});
        cmd_write = 1'b1;
        cmd_addr  = 32'h1E;
        cmd_valid = 1'b1;
        for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge PCLK);
        for (int k = 0; k < 5; k++) begin
            @(negedge PCLK);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'h12345678);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge PCLK);
        #1;
        rsp_ready = 1'b1;
        send_cmd(1'b1, 32'h1E, 32'h0, 4'hF, tb);
        sb.push_back('{32'h00000000, 1'b1, 1'b0, tb + 1});
        wait_drain();

        // Reset during the second wait cycle abandons the transfer.
        slave_waits = 100;
        send_cmd(1'b0, 32'h08, 32'h0, 4'h0, ta);
        @(posedge PCLK);
        #1;
        @(posedge PCLK);
        #1;
        check("mid_access_penable", 32'(PSEL && PENABLE), 32'd1);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        check("abort_psel", 32'(PSEL), 32'd0);
        check("abort_penable", 32'(PENABLE), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        PRESET = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge PCLK);
                if (rsp_valid) seen = 1'b1;
            end
            check("abort_no_response", 32'(seen), 32'd0);
        end
        @(posedge PCLK);
        #1;
        run_vec('{1'b0, 32'h08, 32'h0, 4'h0, 32'h08080808, 0, 1'b0, 32'h08080808, 1'b0, 1'b0, 1, 3});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got no completion expected finish before 500000 time units");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
